dcache_ctrl: RTL
================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 15, ACCESS-state cycles allowed before abort (used only with DCACHE_TIMEOUT_EN).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 mem_v  in  1  MEM latch valid.
REQ-005 mem_dcache_en  in  1  MEM.CS DCACHE.EN (instruction accesses data memory).
REQ-006 mem_dcache_rw  in  1  1 = store, 0 = load.
REQ-007 mem_data_size  in  1  1 = word, 0 = byte.
REQ-008 mem_address  in  16  byte address from the AGEX→MEM latch.
REQ-009 mem_store_data  in  16  store source value.
REQ-010 dcache_r  in  1  memory ready, valid only while dcache_req=1.
REQ-011 dcache_rdata  in  16  aligned word read data, valid with dcache_r.
REQ-012 dcache_req  out  1  access request.
REQ-013 dcache_we  out  1  write enable.
REQ-014 dcache_addr  out  16  word address {mem_address[15:1],1'b0}.
REQ-015 dcache_wdata  out  16  write data.
REQ-016 dcache_wmask  out  2  byte lanes, bit1 = high byte.
REQ-017 mem_stall  out  1  stalls MEM latch and, via LD.MEM, the AGEX stage.
REQ-018 mem_rdata  out  16  registered load result.
REQ-019 mem_unaligned  out  1  word access to odd address.
REQ-020 mem_dcache_err  out  1  one-cycle timeout abort pulse.

Function
REQ-021 FSM states IDLE, ACCESS, DONE; start = mem_v & mem_dcache_en & ~mem_unaligned.
REQ-022 IDLE: start → ACCESS at the next edge; otherwise stay IDLE.
REQ-023 ACCESS: dcache_r=1 → DONE; otherwise stay ACCESS.
REQ-024 DONE → IDLE unconditionally after one cycle; the MEM latch loads the next instruction during DONE, so one instruction never triggers twice.
REQ-025 mem_stall = (IDLE & start) | ACCESS, combinational; it is 0 in DONE.
REQ-026 dcache_req = 1 exactly in ACCESS, registered, no combinational path from inputs.
REQ-027 dcache_we = ACCESS & mem_dcache_rw.
REQ-028 dcache_addr and dcache_wdata are driven combinationally from the MEM latch inputs, which are held stable by mem_stall.
REQ-029 Word store: wmask=11, wdata=mem_store_data.
REQ-030 Byte store: wdata={mem_store_data[7:0],mem_store_data[7:0]}; wmask=01 if address[0]=0, 10 if address[0]=1.
REQ-031 dcache_wmask = 00 whenever dcache_we=0.
REQ-032 Load capture in ACCESS with dcache_r=1 on the same edge as the move to DONE:
- word: mem_rdata = dcache_rdata;
- byte: mem_rdata = the byte selected by address[0], sign-extended to 16 bits.
REQ-033 A store does not update mem_rdata; mem_rdata holds until the next load capture.
REQ-034 mem_unaligned = mem_v & mem_dcache_en & mem_data_size & mem_address[0], combinational. With mem_unaligned=1: no request, no stall, FSM stays IDLE.
REQ-035 Minimum access: stall 2 cycles (IDLE-start, ACCESS with r), then DONE. Each extra ACCESS cycle adds one stall cycle.
REQ-036 dcache_r outside ACCESS is ignored.

Reset
REQ-037 rst=1 forces IDLE immediately, regardless of the current state, including mid-ACCESS (request aborted).
REQ-038 Reset values: dcache_req=0, dcache_we=0, dcache_wmask=00, mem_rdata=0x0000, mem_dcache_err=0, timeout counter=0.
REQ-039 After reset, mem_stall reflects only IDLE & start.

Configuration
REQ-040 Macro DCACHE_TIMEOUT_EN defined:
- a counter clears on entry to ACCESS and increments each ACCESS cycle without dcache_r;
- on reaching TIMEOUT_CYCLES the FSM goes to DONE, mem_rdata is loaded with 0x0000, and mem_dcache_err=1 for the DONE cycle;
- dcache_r on the same cycle as the limit takes priority as a normal completion.
REQ-041 Macro undefined: no counter; ACCESS waits indefinitely; mem_dcache_err tied 0.

Verification
REQ-042 LDW at 0x4000, dcache_r in 1st ACCESS cycle, rdata=0x1234 → mem_stall high 2 cycles, req high 1 cycle, mem_rdata=0x1234 in DONE.
REQ-043 LDB at 0x4001, rdata=0x80FF, r after 3 ACCESS cycles → mem_rdata=0xFF80, mem_stall high 4 cycles.
REQ-044 STB at 0x4000, store_data=0xABCD → we=1, wmask=01, wdata=0xCDCD; STW at 0x4003 → mem_unaligned=1, req=0, stall=0.
REQ-045 rst asserted mid-ACCESS → req=0 and stall=0 without a clock edge; after release, a new access completes normally.
REQ-046 DCACHE_TIMEOUT_EN, TIMEOUT_CYCLES=15, r never asserted → DONE after 15 ACCESS cycles, err pulses once, mem_rdata=0x0000. Without the macro, stall persists for 100 cycles.

Source files
------------

// File: rtl/dcache_ctrl.sv
// MEM-stage data cache access controller: IDLE/ACCESS/DONE handshake with the data memory.
// Optional ACCESS timeout abort is enabled by defining DCACHE_TIMEOUT_EN.
module dcache_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_v,
  input  logic        mem_dcache_en,
  input  logic        mem_dcache_rw,
  input  logic        mem_data_size,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_store_data,
  input  logic        dcache_r,
  input  logic [15:0] dcache_rdata,
  output logic        dcache_req,
  output logic        dcache_we,
  output logic [15:0] dcache_addr,
  output logic [15:0] dcache_wdata,
  output logic [1:0]  dcache_wmask,
  output logic        mem_stall,
  output logic [15:0] mem_rdata,
  output logic        mem_unaligned,
  output logic        mem_dcache_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t     state;
  logic       start;
  logic [7:0] load_byte;

  assign mem_unaligned = mem_v & mem_dcache_en & mem_data_size & mem_address[0];
  assign start         = mem_v & mem_dcache_en & ~mem_unaligned;

  // Gated by rst so a held MEM latch cannot stall the pipe while reset is asserted.
  assign mem_stall = ~rst & (((state == IDLE) & start) | (state == ACCESS));

  assign dcache_we    = dcache_req & mem_dcache_rw;
  assign dcache_addr  = {mem_address[15:1], 1'b0};
  assign dcache_wdata = mem_data_size ? mem_store_data : {2{mem_store_data[7:0]}};
  assign load_byte    = mem_address[0] ? dcache_rdata[15:8] : dcache_rdata[7:0];

  always_comb begin
    dcache_wmask = 2'b00;
    if (dcache_we) begin
      if (mem_data_size) dcache_wmask = 2'b11;
      else               dcache_wmask = mem_address[0] ? 2'b10 : 2'b01;
    end
  end

`ifdef DCACHE_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;
`else
  assign mem_dcache_err = 1'b0;
  // TIMEOUT_CYCLES only matters when the timeout feature is built in.
  if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dcache_req <= 1'b0;
      mem_rdata  <= 16'h0000;
`ifdef DCACHE_TIMEOUT_EN
      mem_dcache_err <= 1'b0;
      tmo_cnt        <= '0;
`endif
    end else begin
`ifdef DCACHE_TIMEOUT_EN
      mem_dcache_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            state      <= ACCESS;
            dcache_req <= 1'b1;
`ifdef DCACHE_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end
        ACCESS: begin
          if (dcache_r) begin
            state      <= DONE;
            dcache_req <= 1'b0;
            if (!mem_dcache_rw)
              mem_rdata <= mem_data_size ? dcache_rdata : {{8{load_byte[7]}}, load_byte};
          end
`ifdef DCACHE_TIMEOUT_EN
          else begin
            tmo_cnt <= tmo_cnt + CW'(1);
            if ((tmo_cnt + CW'(1)) == CW'(TIMEOUT_CYCLES)) begin
              state          <= DONE;
              dcache_req     <= 1'b0;
              mem_rdata      <= 16'h0000;
              mem_dcache_err <= 1'b1;
            end
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
